// File: rtl/smac_pkg.sv
// Shared types, default sizes and helpers for the S_MAC bit-plane feeder.
// Pure declarations; no timing or flow-control behaviour of its own.
// Optional perf counters in the top are enabled by SMAC_FEED_PERF_EN.
package smac_pkg;

   localparam int SMAC_M  = 16;
   localparam int SMAC_PA = 8;
   localparam int SMAC_PW = 4;

   // Upper bounds for the generic plane selector (lanes, flattened vector bits).
   localparam int PLANE_MAX = 64;
   localparam int VEC_MAX   = 1024;
   localparam int VEC_IW    = 10;

   typedef enum logic {IDLE, RUN} feed_state_t;

   // Index width that never collapses to zero for single-bit operands.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Bit idx of every width-bit lane packed in vec, gathered into one plane.
   function automatic logic [PLANE_MAX-1:0] plane_sel(input logic [VEC_MAX-1:0] vec,
                                                      input int idx, input int width);
      logic [PLANE_MAX-1:0] plane;
      int pos;
      plane = '0;
      for (int k = 0; k < PLANE_MAX; k++) begin
         pos = k * width + idx;
         if (pos < VEC_MAX) plane[k] = vec[pos[VEC_IW-1:0]];
      end
      return plane;
   endfunction

endpackage

// File: rtl/smac_bitplane_feeder_if.sv
// Upstream vector handshake into the bit-plane feeder.
// No logic; carries one vector per in_valid && in_ready.
// Backpressure via in_ready driven by the slave side.
interface smac_bitplane_feeder_if
   import smac_pkg::*;
#(
   parameter int M  = SMAC_M,
   parameter int PA = SMAC_PA,
   parameter int PW = SMAC_PW
);
   logic            in_valid;
   logic            in_ready;
   logic [M*PA-1:0] in_act;
   logic [M*PW-1:0] in_wei;
   logic            in_last;

   modport master (output in_valid, in_act, in_wei, in_last, input in_ready);
   modport slave  (input in_valid, in_act, in_wei, in_last, output in_ready);
endinterface

// File: rtl/smac_plane_counter.sv
// Nested down-counter over (w_idx, a_idx): a_idx inner, w_idx outer, MSB first.
// Load takes effect next cycle; one step per cycle.
// Holds at (0,0) after the final beat until reloaded; no backpressure.
module smac_plane_counter
   import smac_pkg::*;
#(
   parameter int PA = SMAC_PA,
   parameter int PW = SMAC_PW,
   parameter int AW = idx_w(PA),
   parameter int WW = idx_w(PW)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          step,
   output logic [AW-1:0] a_idx,
   output logic [WW-1:0] w_idx,
   output logic          a_top,
   output logic          w_top,
   output logic          a_wrap,
   output logic          last
);
   localparam logic [AW-1:0] A_MAX = AW'(PA - 1);
   localparam logic [WW-1:0] W_MAX = WW'(PW - 1);

   assign a_top  = (a_idx == A_MAX);
   assign w_top  = (w_idx == W_MAX);
   assign a_wrap = (a_idx == '0);
   assign last   = a_wrap && (w_idx == '0);

   // Restart at the sign planes on load, otherwise walk down until (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_idx <= '0;
         w_idx <= '0;
      end else if (load) begin
         a_idx <= A_MAX;
         w_idx <= W_MAX;
      end else if (step && !last) begin
         if (a_wrap) begin
            a_idx <= A_MAX;
            w_idx <= w_idx - 1'b1;
         end else begin
            a_idx <= a_idx - 1'b1;
         end
      end
   end
endmodule

// File: rtl/smac_bitplane_feeder.sv
// Serialises M-lane act/wei vectors into bit-planes (weight outer, act inner, MSB first).
// First beat 1 cycle after acceptance from IDLE; Pa*Pw beats per vector, queued vectors follow gap-free.
// One-entry skid: in_ready = !skid_full. Optional SMAC_FEED_PERF_EN adds stall_cnt/vec_cnt.
module smac_bitplane_feeder
   import smac_pkg::*;
#(
   parameter int M  = SMAC_M,
   parameter int Pa = SMAC_PA,
   parameter int Pw = SMAC_PW
) (
   input  logic                   clk,
   input  logic                   rst_n,
   smac_bitplane_feeder_if.slave  in_if,
   output logic [M-1:0]           out_act,
   output logic [M-1:0]           out_wei,
   output logic                   w_en_a,
   output logic                   w_en_w,
   output logic                   MSB_a,
   output logic                   MSB_w,
   output logic [idx_w(Pa)-1:0]   a_idx,
   output logic [idx_w(Pw)-1:0]   w_idx,
   output logic                   a_sweep_last,
   output logic                   vec_last,
   output logic                   dot_last,
   output logic                   busy
`ifdef SMAC_FEED_PERF_EN
   ,
   output logic [31:0]            stall_cnt,
   output logic [31:0]            vec_cnt
`endif
);
   feed_state_t       state_q, state_d;
   logic [M*Pa-1:0]   act_q, skid_act_q;
   logic [M*Pw-1:0]   wei_q, skid_wei_q;
   logic              last_q, skid_last_q, skid_full_q;
   logic              run, accept;
   logic              cnt_load, cnt_step, cnt_a_top, cnt_w_top, cnt_a_wrap, cnt_last;
   logic              act_ld_in, act_ld_skid, skid_ld, skid_clr;

   assign run             = (state_q == RUN);
   assign in_if.in_ready  = !skid_full_q;
   assign accept          = in_if.in_valid && !skid_full_q;

   smac_plane_counter #(.PA(Pa), .PW(Pw)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (cnt_load),
      .step   (cnt_step),
      .a_idx  (a_idx),
      .w_idx  (w_idx),
      .a_top  (cnt_a_top),
      .w_top  (cnt_w_top),
      .a_wrap (cnt_a_wrap),
      .last   (cnt_last)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and buffer steering: bypass to active when free, else park in skid.
   always_comb begin
      state_d     = state_q;
      cnt_load    = 1'b0;
      cnt_step    = 1'b0;
      act_ld_in   = 1'b0;
      act_ld_skid = 1'b0;
      skid_ld     = 1'b0;
      skid_clr    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               act_ld_in = 1'b1;
               cnt_load  = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (cnt_last) begin
               if (skid_full_q) begin
                  act_ld_skid = 1'b1;
                  cnt_load    = 1'b1;
                  if (accept) skid_ld  = 1'b1;
                  else        skid_clr = 1'b1;
               end else if (accept) begin
                  act_ld_in = 1'b1;
                  cnt_load  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_step = 1'b1;
               if (accept) skid_ld = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Active and skid vector storage; reset discards both without flushing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q       <= '0;
         wei_q       <= '0;
         last_q      <= 1'b0;
         skid_act_q  <= '0;
         skid_wei_q  <= '0;
         skid_last_q <= 1'b0;
         skid_full_q <= 1'b0;
      end else begin
         if (act_ld_in) begin
            act_q  <= in_if.in_act;
            wei_q  <= in_if.in_wei;
            last_q <= in_if.in_last;
         end else if (act_ld_skid) begin
            act_q  <= skid_act_q;
            wei_q  <= skid_wei_q;
            last_q <= skid_last_q;
         end
         if (skid_ld) begin
            skid_act_q  <= in_if.in_act;
            skid_wei_q  <= in_if.in_wei;
            skid_last_q <= in_if.in_last;
            skid_full_q <= 1'b1;
         end else if (skid_clr) begin
            skid_full_q <= 1'b0;
         end
      end
   end

   // Planes come straight from registers; in IDLE the counter rests at (0,0)
   // and the active vector is untouched, so the last plane is held.
   assign out_act      = M'(plane_sel(VEC_MAX'(act_q), int'(a_idx), Pa));
   assign out_wei      = M'(plane_sel(VEC_MAX'(wei_q), int'(w_idx), Pw));
   assign busy         = run;
   assign w_en_a       = run;
   assign w_en_w       = run && cnt_a_top;
   assign MSB_a        = (Pa == 1) ? 1'b1 : (run && cnt_a_top);
   assign MSB_w        = (Pw == 1) ? 1'b1 : (run && cnt_w_top);
   assign a_sweep_last = run && cnt_a_wrap;
   assign vec_last     = run && cnt_last;
   assign dot_last     = run && cnt_last && last_q;

`ifdef SMAC_FEED_PERF_EN
   logic seen_q;

   // Saturating counters: idle cycles once traffic has started, and finished vectors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_q    <= 1'b0;
         stall_cnt <= '0;
         vec_cnt   <= '0;
      end else begin
         if (accept) seen_q <= 1'b1;
         if (!run && seen_q && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
         if (vec_last && (vec_cnt != '1)) vec_cnt <= vec_cnt + 32'd1;
      end
   end
`endif
endmodule
